conv_sched: RTL and testbench

- Sequencer that runs one 3x3 convolution pass over a 4-bit-per-pixel image held in the coprocessor's on-chip image buffer.
- Streams pixels from a source region through a 3-column sliding window and presents the window plus a function code to the 3x3 convolution processing element.
- Writes each filtered pixel to a destination region.
- Started by the coprocessor command decoder; reports busy/done back to it.

---
 rtl/conv_sched_pkg.sv | 37 +++
 rtl/conv_window_reg.sv | 68 ++++++
 rtl/conv_sched.sv | 179 +++++++++++++++++
 tb/tb_conv_sched.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and helpers for the 3x3 convolution pass sequencer.
package conv_sched_pkg;

    typedef enum logic [1:0] {
        FN_EDGE  = 2'b00,
        FN_BLUR  = 2'b01,
        FN_SHARP = 2'b10,
        FN_NOP   = 2'b11
    } func_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    // Width of the row/column counters carried in the read tag.
    localparam int unsigned IDX_W = 12;

    typedef struct packed {
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
        logic [1:0]       phase;
    } rd_tag_t;

    // Border-replicate clamp of (v - 1) into 0..hi; callers pass v pre-biased by +1.
    function automatic logic [IDX_W-1:0] clamp_dec(input logic [IDX_W-1:0] v,
                                                   input logic [IDX_W-1:0] hi);
        logic [IDX_W-1:0] d;
        d = v - IDX_W'(1);
        if (v == '0) return '0;
        if (d > hi) return hi;
        return d;
    endfunction

endpackage

// File: rtl/conv_window_reg.sv
// 3x3 sliding window: stages the two upper rows of each column, then shifts
// a full column in on the third phase and flags windows centred on real pixels.
module conv_window_reg
    import conv_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  rd_tag_t          in_tag,
    input  logic [3:0]       in_data,
    output logic [3:0]       win00,
    output logic [3:0]       win01,
    output logic [3:0]       win02,
    output logic [3:0]       win10,
    output logic [3:0]       win11,
    output logic [3:0]       win12,
    output logic [3:0]       win20,
    output logic [3:0]       win21,
    output logic [3:0]       win22,
    output logic             win_valid,
    output logic [IDX_W-1:0] win_row,
    output logic [IDX_W-1:0] win_col
);

    logic [3:0] stage0;
    logic [3:0] stage1;
    logic       shift;

    assign shift = in_vld && (in_tag.phase == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage0    <= '0;
            stage1    <= '0;
            win00     <= '0;
            win01     <= '0;
            win02     <= '0;
            win10     <= '0;
            win11     <= '0;
            win12     <= '0;
            win20     <= '0;
            win21     <= '0;
            win22     <= '0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            // Columns 0 and 1 of a row only prime the window; no output for them.
            win_valid <= shift && (in_tag.col >= IDX_W'(2));
            if (in_vld && (in_tag.phase == 2'd0)) stage0 <= in_data;
            if (in_vld && (in_tag.phase == 2'd1)) stage1 <= in_data;
            if (shift) begin
                win00   <= win01;
                win01   <= win02;
                win02   <= stage0;
                win10   <= win11;
                win11   <= win12;
                win12   <= stage1;
                win20   <= win21;
                win21   <= win22;
                win22   <= in_data;
                win_row <= in_tag.row;
                win_col <= in_tag.col;
            end
        end
    end

endmodule

// File: rtl/conv_sched.sv
// Convolution pass sequencer: generates clamped source reads, feeds the window
// register to the external convolution element and writes results in raster order.
module conv_sched
    import conv_sched_pkg::*;
#(
    parameter int unsigned IMG_W  = 160,
    parameter int unsigned IMG_H  = 120,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        func_in,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [3:0]        rd_data,
    output logic [3:0]        win00,
    output logic [3:0]        win01,
    output logic [3:0]        win02,
    output logic [3:0]        win10,
    output logic [3:0]        win11,
    output logic [3:0]        win12,
    output logic [3:0]        win20,
    output logic [3:0]        win21,
    output logic [3:0]        win22,
    output logic [1:0]        func_out,
    input  logic [3:0]        conv_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_data
);

    localparam logic [IDX_W-1:0]  C_LAST     = IDX_W'(IMG_W + 1);
    localparam logic [IDX_W-1:0]  Y_LAST     = IDX_W'(IMG_H - 1);
    localparam logic [IDX_W-1:0]  X_MAX      = IDX_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);

    state_e            state;
    state_e            state_n;
    func_e             func_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [IDX_W-1:0]  y;
    logic [IDX_W-1:0]  c;
    logic [1:0]        k;
    logic [1:0]        flush_cnt;
    logic              accept;
    logic              last_rd;
    logic [IDX_W-1:0]  row_cl;
    logic [IDX_W-1:0]  col_cl;
    logic [ADDR_W-1:0] rd_addr_raw;
    rd_tag_t           tag_q;
    logic              tag_vld;
    logic              win_valid;
    logic [IDX_W-1:0]  win_row;
    logic [IDX_W-1:0]  win_col;

    assign accept  = (state == ST_IDLE) && start;
    assign last_rd = (y == Y_LAST) && (c == C_LAST) && (k == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        rd_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_n = ST_RUN;
            end
            ST_RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (last_rd) state_n = ST_FLUSH;
            end
            // Covers read latency, the final window shift and the final write.
            ST_FLUSH: begin
                busy = 1'b1;
                if (flush_cnt == 2'd2) state_n = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_q    <= FN_EDGE;
            src_q     <= '0;
            dst_q     <= '0;
            y         <= '0;
            c         <= '0;
            k         <= '0;
            flush_cnt <= '0;
            tag_q     <= '0;
            tag_vld   <= 1'b0;
        end else begin
            tag_vld   <= rd_en;
            tag_q     <= '{row: y, col: c, phase: k};
            flush_cnt <= (state == ST_FLUSH) ? flush_cnt + 2'd1 : '0;
            if (accept) begin
                func_q <= func_e'(func_in);
                src_q  <= src_base;
                dst_q  <= dst_base;
                y      <= '0;
                c      <= '0;
                k      <= '0;
            end else if (state == ST_RUN) begin
                if (k == 2'd2) begin
                    k <= '0;
                    if (c == C_LAST) begin
                        c <= '0;
                        y <= y + IDX_W'(1);
                    end else begin
                        c <= c + IDX_W'(1);
                    end
                end else begin
                    k <= k + 2'd1;
                end
            end
        end
    end

    // Phase k selects the window row (y-1..y+1); column counter is biased by +1.
    always_comb begin
        row_cl      = clamp_dec(y + IDX_W'(k), Y_LAST);
        col_cl      = clamp_dec(c, X_MAX);
        rd_addr_raw = src_q + ADDR_W'(row_cl) * ROW_STRIDE + ADDR_W'(col_cl);
    end

    assign rd_addr  = rd_en ? rd_addr_raw : '0;
    assign func_out = func_q;

    conv_window_reg u_window (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (tag_vld),
        .in_tag    (tag_q),
        .in_data   (rd_data),
        .win00     (win00),
        .win01     (win01),
        .win02     (win02),
        .win10     (win10),
        .win11     (win11),
        .win12     (win12),
        .win20     (win20),
        .win21     (win21),
        .win22     (win22),
        .win_valid (win_valid),
        .win_row   (win_row),
        .win_col   (win_col)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= win_valid;
            if (win_valid) begin
                wr_addr <= dst_q + ADDR_W'(win_row) * ROW_STRIDE + ADDR_W'(win_col) - ADDR_W'(2);
                wr_data <= conv_result;
            end
        end
    end

endmodule

// File: tb/tb_conv_sched.sv
// Bench for conv_sched: randomized images and bases compared against a direct
// per-pixel 3x3 border-replicate model of the filtered image.
`timescale 1ns/1ps
module tb_conv_sched;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int AW    = 15;
    localparam int NPIX  = W * H;
    localparam int NRD   = H * (W + 2) * 3;
    localparam int MEMSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    func_in = '0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [3:0]    rd_data = '0;
    logic [3:0]    wr_data, conv_result;
    logic [3:0]    win00, win01, win02, win10, win11, win12, win20, win21, win22;
    logic [1:0]    func_out;

    logic [3:0]    mem [MEMSZ];
    int            checks = 0;
    int            errors = 0;

    logic [AW-1:0] wr_a [$];
    logic [3:0]    wr_d [$];
    logic [AW-1:0] rd_a [$];
    int            busy_cyc, done_cnt, done_cyc, first_rd, last_rd, last_wr, func_bad;

    conv_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func_in(func_in),
        .src_base(src_base), .dst_base(dst_base), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .win00(win00), .win01(win01), .win02(win02),
        .win10(win10), .win11(win11), .win12(win12),
        .win20(win20), .win21(win21), .win22(win22),
        .func_out(func_out), .conv_result(conv_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    // Stand-in convolution element; n[r*3+j] is row r, column j.
    function automatic logic [3:0] kernel(input logic [8:0][3:0] n, input logic [1:0] f);
        int s, cen, v;
        cen = int'(n[4]);
        s = 0;
        for (int i = 0; i < 9; i++) if (i != 4) s += int'(n[i]);
        case (f)
            2'b00: begin
                v = 8 * cen - s;
                if (v < 0) v = -v;
                v = (v + 7) / 16;
            end
            2'b01: v = (s + cen) / 9;
            2'b10: begin
                v = 5 * cen - int'(n[1]) - int'(n[3]) - int'(n[5]) - int'(n[7]);
                if (v < 0) v = 0;
                if (v > 15) v = 15;
            end
            default: v = cen;
        endcase
        return v[3:0];
    endfunction

    always_comb conv_result = kernel({win22, win21, win20, win12, win11, win10, win02, win01, win00}, func_out);

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic [3:0] ref_pixel(input logic [AW-1:0] s, input int i, input logic [1:0] f);
        logic [8:0][3:0] n;
        int yy, xx;
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < 3; j++) begin
                yy = clampi(i / W + r - 1, H - 1);
                xx = clampi(i % W + j - 1, W - 1);
                n[r*3+j] = mem[(int'(s) + yy * W + xx) % MEMSZ];
            end
        return kernel(n, f);
    endfunction

    function automatic logic [AW-1:0] exp_wr_addr(input logic [AW-1:0] d, input int i);
        return AW'(int'(d) + i);
    endfunction

    function automatic logic [AW-1:0] exp_rd_addr(input logic [AW-1:0] s, input int idx);
        int yy, cc, kk;
        yy = idx / ((W + 2) * 3);
        cc = (idx % ((W + 2) * 3)) / 3;
        kk = idx % 3;
        return AW'(int'(s) + clampi(yy + kk - 1, H - 1) * W + clampi(cc - 1, W - 1));
    endfunction

    task automatic fill_random(input logic [AW-1:0] s);
        for (int i = 0; i < NPIX; i++) mem[(int'(s) + i) % MEMSZ] = 4'($urandom);
    endtask

    task automatic fill_const(input logic [AW-1:0] s, input logic [3:0] v);
        for (int i = 0; i < NPIX; i++) mem[(int'(s) + i) % MEMSZ] = v;
    endtask

    task automatic run_pass(input logic [1:0] f, input logic [AW-1:0] s,
                            input logic [AW-1:0] d, input bit poke);
        int cyc, post;
        wr_a.delete(); wr_d.delete(); rd_a.delete();
        busy_cyc = 0; done_cnt = 0; done_cyc = -1; first_rd = -1; last_rd = -1;
        last_wr = -1; func_bad = 0;
        @(negedge clk);
        func_in = f; src_base = s; dst_base = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        func_in = 2'($urandom); src_base = AW'($urandom); dst_base = AW'($urandom);
        cyc = 1;
        post = 0;
        while (post < 4 && cyc < 2000) begin
            if (busy) busy_cyc++;
            if (func_out !== f) func_bad++;
            if (rd_en) begin
                rd_a.push_back(rd_addr);
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (wr_en) begin
                wr_a.push_back(wr_addr);
                wr_d.push_back(wr_data);
                last_wr = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done_cnt > 0) post++;
            start = poke && (cyc == 5 || cyc == 30 || cyc == 56 || cyc == NRD + 4);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, rd_en, wr_en} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, rd_en, wr_en});
        end
        checks++;
        if ({rd_addr, wr_addr, wr_data, func_out} !== '0) begin
            errors++; $display("FAIL reset_bus: got %h/%h/%h/%h expected 0", rd_addr, wr_addr, wr_data, func_out);
        end
        checks++;
        if ({win00, win01, win02, win10, win11, win12, win20, win21, win22} !== '0) begin
            errors++; $display("FAIL reset_win: got %h expected 0",
                               {win00, win01, win02, win10, win11, win12, win20, win21, win22});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        for (int i = 0; i < NPIX; i++) mem[i] = 4'(i);
        run_pass(2'b11, AW'(0), AW'('h20), 1'b0);
        checks++;
        if (wr_a.size() !== NPIX) begin
            errors++; $display("FAIL ramp_count: got %0d expected %0d", wr_a.size(), NPIX);
        end
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (wr_a[i] !== AW'('h20 + i) || wr_d[i] !== 4'(i)) begin
                errors++; $display("FAIL ramp_wr[%0d]: got %h/%h expected %h/%h", i, wr_a[i], wr_d[i], AW'('h20 + i), 4'(i));
            end
        end
        checks++;
        if (busy_cyc !== NRD + 3) begin
            errors++; $display("FAIL ramp_busy: got %0d expected %0d", busy_cyc, NRD + 3);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== last_wr + 1) begin
            errors++; $display("FAIL ramp_done: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_cyc, last_wr + 1);
        end
        checks++;
        if (rd_a.size() !== NRD || first_rd !== 1 || last_rd !== NRD) begin
            errors++; $display("FAIL ramp_reads: got %0d reads cyc %0d..%0d expected %0d reads cyc 1..%0d",
                               rd_a.size(), first_rd, last_rd, NRD, NRD);
        end
        checks++;
        if (func_bad !== 0) begin
            errors++; $display("FAIL ramp_func_out: got %0d bad cycles expected 0", func_bad);
        end
    endtask

    task automatic test_blur_const();
        logic [AW-1:0] s, d;
        s = AW'($urandom_range(0, 'h3FFF));
        d = s + AW'('h4000);
        fill_const(s, 4'hA);
        run_pass(2'b01, s, d, 1'b0);
        checks++;
        if (wr_a.size() !== NPIX) begin
            errors++; $display("FAIL blur_count: got %0d expected %0d", wr_a.size(), NPIX);
        end
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (wr_a[i] !== exp_wr_addr(d, i) || wr_d[i] !== 4'hA) begin
                errors++; $display("FAIL blur_wr[%0d]: got %h/%h expected %h/a", i, wr_a[i], wr_d[i], exp_wr_addr(d, i));
            end
        end
    endtask

    task automatic test_edge_impulse();
        logic [AW-1:0] s, d;
        s = AW'($urandom_range(0, 'h3FFF));
        d = s + AW'('h4000);
        fill_const(s, 4'h0);
        mem[(int'(s) + W + 1) % MEMSZ] = 4'hF;
        run_pass(2'b00, s, d, 1'b0);
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (wr_a[i] !== exp_wr_addr(d, i) || wr_d[i] !== ref_pixel(s, i, 2'b00)) begin
                errors++; $display("FAIL edge_wr[%0d]: got %h/%h expected %h/%h", i, wr_a[i], wr_d[i],
                                   exp_wr_addr(d, i), ref_pixel(s, i, 2'b00));
            end
        end
        checks++;
        if (wr_d[W + 1] !== 4'h7 || wr_d[0] !== 4'h1 || wr_d[2*W + 2] !== 4'h1) begin
            errors++; $display("FAIL edge_points: got %h/%h/%h expected 7/1/1", wr_d[W + 1], wr_d[0], wr_d[2*W + 2]);
        end
        checks++;
        if (wr_d[W - 1] !== 4'h0 || wr_d[NPIX - 1] !== 4'h0) begin
            errors++; $display("FAIL edge_far: got %h/%h expected 0/0", wr_d[W - 1], wr_d[NPIX - 1]);
        end
    endtask

    task automatic test_addr();
        logic [1:0] f;
        f = 2'($urandom);
        fill_random(AW'('h100));
        run_pass(f, AW'('h100), AW'('h200), 1'b0);
        checks++;
        if (rd_a[0] !== AW'('h100) || rd_a[1] !== AW'('h100) || rd_a[2] !== AW'('h104) || rd_a[NRD-1] !== AW'('h10B)) begin
            errors++; $display("FAIL addr_rd_points: got %h %h %h last %h expected 100 100 104 last 10b",
                               rd_a[0], rd_a[1], rd_a[2], rd_a[NRD-1]);
        end
        for (int i = 0; i < NRD; i++) begin
            checks++;
            if (rd_a[i] !== exp_rd_addr(AW'('h100), i)) begin
                errors++; $display("FAIL addr_rd[%0d]: got %h expected %h", i, rd_a[i], exp_rd_addr(AW'('h100), i));
            end
        end
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (wr_a[i] !== AW'('h200 + i) || wr_d[i] !== ref_pixel(AW'('h100), i, f)) begin
                errors++; $display("FAIL addr_wr[%0d]: got %h/%h expected %h/%h", i, wr_a[i], wr_d[i],
                                   AW'('h200 + i), ref_pixel(AW'('h100), i, f));
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [AW-1:0] s, d;
        logic [1:0] f;
        s = AW'($urandom_range(0, 'h3FFF));
        d = s + AW'('h4000);
        f = 2'($urandom);
        fill_random(s);
        run_pass(f, s, d, 1'b1);
        checks++;
        if (wr_a.size() !== NPIX || done_cnt !== 1 || busy_cyc !== NRD + 3) begin
            errors++; $display("FAIL poke_counts: got %0d writes %0d done %0d busy expected %0d/1/%0d",
                               wr_a.size(), done_cnt, busy_cyc, NPIX, NRD + 3);
        end
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (wr_a[i] !== exp_wr_addr(d, i) || wr_d[i] !== ref_pixel(s, i, f)) begin
                errors++; $display("FAIL poke_wr[%0d]: got %h/%h expected %h/%h", i, wr_a[i], wr_d[i],
                                   exp_wr_addr(d, i), ref_pixel(s, i, f));
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [AW-1:0] s, d;
        logic [1:0] f;
        int activity;
        s = AW'($urandom_range(0, 'h3FFF));
        d = s + AW'('h4000);
        f = 2'($urandom);
        fill_random(s);
        @(negedge clk);
        func_in = f; src_base = s; dst_base = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data, func_out} !== '0 ||
            {win00, win01, win02, win10, win11, win12, win20, win21, win22} !== '0) begin
            errors++; $display("FAIL abort_outputs: got %b %h %h %h expected all 0",
                               {busy, done, rd_en, wr_en}, rd_addr, wr_addr, wr_data);
        end
        activity = 0;
        repeat (4) @(negedge clk) if (busy || done || rd_en || wr_en) activity++;
        rst_n = 1'b1;
        repeat (6) @(negedge clk) if (busy || done || rd_en || wr_en) activity++;
        checks++;
        if (activity !== 0) begin
            errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", activity);
        end
        run_pass(f, s, d, 1'b0);
        checks++;
        if (wr_a.size() !== NPIX || done_cnt !== 1) begin
            errors++; $display("FAIL abort_rerun_counts: got %0d writes %0d done expected %0d/1", wr_a.size(), done_cnt, NPIX);
        end
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (wr_a[i] !== exp_wr_addr(d, i) || wr_d[i] !== ref_pixel(s, i, f)) begin
                errors++; $display("FAIL abort_rerun_wr[%0d]: got %h/%h expected %h/%h", i, wr_a[i], wr_d[i],
                                   exp_wr_addr(d, i), ref_pixel(s, i, f));
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] s, d;
        logic [1:0] f;
        for (int n = 0; n < 4; n++) begin
            s = AW'($urandom);
            d = s + AW'($urandom_range(NPIX, MEMSZ - NPIX));
            f = 2'(n);
            fill_random(s);
            run_pass(f, s, d, 1'b0);
            checks++;
            if (wr_a.size() !== NPIX || done_cnt !== 1) begin
                errors++; $display("FAIL rand%0d_counts: got %0d writes %0d done expected %0d/1", n, wr_a.size(), done_cnt, NPIX);
            end
            for (int i = 0; i < NPIX; i++) begin
                checks++;
                if (wr_a[i] !== exp_wr_addr(d, i) || wr_d[i] !== ref_pixel(s, i, f)) begin
                    errors++; $display("FAIL rand%0d_wr[%0d]: got %h/%h expected %h/%h", n, i, wr_a[i], wr_d[i],
                                       exp_wr_addr(d, i), ref_pixel(s, i, f));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_blur_const();
        test_edge_impulse();
        test_addr();
        test_start_ignored();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
